haar_cascade_scheduler: RTL and testbench
=========================================

Name: haar_cascade_scheduler

Overview:
- Sequences the Haar cascade for one detection window at a time.
- Walks the stage table ROM entry by entry, formatted as {num_weak_classifiers[31:16], start_address[15:0]}.
- Starts the stage evaluator once per stage and rejects early on the first failing stage.
- Reports one detect/reject result per window over a valid/ready handshake.
- Sits between the window loader upstream and the stage evaluator plus stage table ROM downstream.

Parameters:
- NUM_STAGES, 3: number of cascade stages; table entries 0..NUM_STAGES-1.
- ADDR_W, 16: stage table address width.
- TAG_W, 16: window tag width, passed through unchanged.
- TIMEOUT, 4096: maximum cycles allowed from eval_start to eval_done.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- win_valid  in  1  a new window is loaded and ready to classify.
- win_ready  out  1  scheduler can accept a window.
- win_tag  in  TAG_W  window identifier.
- tbl_addr  out  ADDR_W  stage table ROM address (synchronous ROM, 1-cycle read latency).
- tbl_data  in  32  stage table entry.
- eval_start  out  1  one-cycle start pulse to the stage evaluator.
- eval_base  out  16  first weak-classifier address for the stage.
- eval_count  out  16  number of weak classifiers in the stage.
- eval_done  in  1  evaluator finished (one-cycle pulse).
- eval_pass  in  1  stage result, valid only when eval_done=1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_detect  out  1  1 = all stages passed.
- res_tag  out  TAG_W  tag of the reported window.
- res_stages  out  8  count of stages passed.
- res_timeout  out  1  rejection was caused by a watchdog timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All outputs go to 0, except win_ready=1.
  - Reset mid-window aborts the window silently; no result is produced.
- States: IDLE, FETCH, LATCH, START, WAIT, NEXT, REPORT.
- IDLE:
  - win_ready=1.
  - On win_valid&win_ready: capture win_tag, set stage_idx=0, tbl_addr=0, clear stages-passed and timeout flag, go to FETCH.
- FETCH: one wait cycle for ROM latency, then go to LATCH.
- LATCH:
  - Register eval_count=tbl_data[31:16] and eval_base=tbl_data[15:0].
  - If tbl_data[31:16]==0, the stage passes vacuously; go to NEXT with no evaluator start.
  - Otherwise go to START.
- START:
  - eval_start=1 for exactly this cycle.
  - Clear the watchdog; go to WAIT.
  - eval_base and eval_count stay stable from LATCH until leaving WAIT.
- WAIT:
  - On eval_done with eval_pass=1: go to NEXT.
  - On eval_done with eval_pass=0: go to REPORT with res_detect=0.
  - If the watchdog reaches TIMEOUT without eval_done: go to REPORT with res_detect=0 and res_timeout=1.
  - eval_done in the same cycle as watchdog expiry: eval_done wins.
- NEXT:
  - Increment res_stages (saturates at 255).
  - If stage_idx==NUM_STAGES-1: go to REPORT with res_detect=1.
  - Otherwise increment stage_idx and tbl_addr, go to FETCH.
- REPORT:
  - res_valid=1; res_detect, res_tag, res_stages and res_timeout are held stable until res_ready.
  - On res_valid&res_ready: drop res_valid, go to IDLE.
- Ignored inputs:
  - eval_done outside WAIT is ignored.
  - win_valid outside IDLE is ignored; win_ready=0 there.
- Latency:
  - Per stage that runs the evaluator: 4 cycles + L, where L is cycles from eval_start to eval_done.
  - Zero-count stage: 3 cycles.
  - Window accept to res_valid, all pass: sum of per-stage cycles.
- No combinational path from any input to any output except through state registers.

Decomposition:
- Shared package haar_pkg holds:
  - State enum.
  - Stage entry field constants (CNT_MSB=31, CNT_LSB=16, BASE_MSB=15, BASE_LSB=0).
  - Default NUM_STAGES and TIMEOUT.
- One sub-module, haar_stage_watchdog:
  - Loadable counter with clear and enable inputs and an expired output.
  - Width is clog2(TIMEOUT+1).

Test Plan:
- Table {3,0x0000},{2,0x0003},{4,0x0005}; evaluator passes every stage with L=5; win_tag=0x00A1:
  - Expect tbl_addr 0,1,2 in turn.
  - Expect eval_base 0x0000/0x0003/0x0005 with eval_count 3/2/4.
  - Expect res_detect=1, res_stages=3, res_tag=0x00A1.
  - Expect res_valid 27 cycles after accept.
- Same table, stage 1 fails: expect exactly 2 eval_start pulses, tbl_addr never 2, res_detect=0, res_stages=1, res_timeout=0.
- Stage 0 entry {0,0x0000}: expect no eval_start for stage 0, res_stages counts it as passed, stage 1 fetched 3 cycles after stage 0 fetch.
- With TIMEOUT=16, evaluator never asserts eval_done: expect res_valid with res_detect=0, res_timeout=1, res_stages=0.
- Hold res_ready=0 for 10 cycles while sending a second win_valid: expect win_ready=0, outputs stable, second window accepted only after handshake and return to IDLE.
- Assert reset during WAIT of stage 1: expect immediate IDLE, eval_start=0, res_valid=0, win_ready=1, no stale result after release.

Source files
------------

// File: rtl/haar_pkg.sv
// Shared types and constants for the Haar cascade scheduler and its watchdog.
// Stage table entries are packed as {num_weak_classifiers, start_address}.
`timescale 1ns/1ps
package haar_pkg;

   localparam int DEF_NUM_STAGES = 3;
   localparam int DEF_TIMEOUT    = 4096;

   localparam int CNT_MSB  = 31;
   localparam int CNT_LSB  = 16;
   localparam int BASE_MSB = 15;
   localparam int BASE_LSB = 0;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LATCH  = 3'd2,
      S_START  = 3'd3,
      S_WAIT   = 3'd4,
      S_NEXT   = 3'd5,
      S_REPORT = 3'd6
   } state_t;

   function automatic logic [15:0] entry_count(input logic [31:0] entry);
      return entry[CNT_MSB:CNT_LSB];
   endfunction

   function automatic logic [15:0] entry_base(input logic [31:0] entry);
      return entry[BASE_MSB:BASE_LSB];
   endfunction

endpackage

// File: rtl/haar_stage_watchdog.sv
// Per-stage watchdog: cleared when a stage starts, counts while the evaluator
// is busy and saturates at TIMEOUT, where expired_o stays high.
`timescale 1ns/1ps
module haar_stage_watchdog
   import haar_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int WD_W    = $clog2(TIMEOUT + 1)
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   logic [WD_W-1:0] cnt_q;
   logic [WD_W-1:0] cnt_d;

   assign expired_o = (cnt_q == WD_W'(TIMEOUT));

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + WD_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/haar_cascade_scheduler.sv
// Walks the stage table for one detection window, starts the evaluator once per
// stage, rejects on the first failing or timed-out stage and reports the result.
`timescale 1ns/1ps
module haar_cascade_scheduler
   import haar_pkg::*;
#(
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int ADDR_W     = 16,
   parameter int TAG_W      = 16,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic              clk_i,
   input  logic              reset_i,
   // Window intake: a transfer happens on a cycle where valid and ready are both
   // high at the clock edge; the same rule applies to the result port.
   input  logic              win_valid_i,
   output logic              win_ready_o,
   input  logic [TAG_W-1:0]  win_tag_i,
   output logic [ADDR_W-1:0] tbl_addr_o,
   input  logic [31:0]       tbl_data_i,
   output logic              eval_start_o,
   output logic [15:0]       eval_base_o,
   output logic [15:0]       eval_count_o,
   input  logic              eval_done_i,
   input  logic              eval_pass_i,
   output logic              res_valid_o,
   input  logic              res_ready_i,
   output logic              res_detect_o,
   output logic [TAG_W-1:0]  res_tag_o,
   output logic [7:0]        res_stages_o,
   output logic              res_timeout_o,
   output logic              busy_o,
   output state_t            state_o
);

   localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   state_t              state_q;
   logic [IDX_W-1:0]    stage_idx_q;
   logic [ADDR_W-1:0]   tbl_addr_q;
   logic                win_ready_q;
   logic                eval_start_q;
   logic [15:0]         eval_base_q;
   logic [15:0]         eval_count_q;
   logic                res_valid_q;
   logic                res_detect_q;
   logic [TAG_W-1:0]    res_tag_q;
   logic [7:0]          res_stages_q;
   logic                res_timeout_q;
   logic                busy_q;

   logic                wd_clear;
   logic                wd_en;
   logic                wd_expired;

   assign wd_clear = (state_q == S_START);
   assign wd_en    = (state_q == S_WAIT);

   haar_stage_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .clear_i   (wd_clear),
      .en_i      (wd_en),
      .expired_o (wd_expired)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         stage_idx_q   <= '0;
         tbl_addr_q    <= '0;
         win_ready_q   <= 1'b1;
         eval_start_q  <= 1'b0;
         eval_base_q   <= '0;
         eval_count_q  <= '0;
         res_valid_q   <= 1'b0;
         res_detect_q  <= 1'b0;
         res_tag_q     <= '0;
         res_stages_q  <= '0;
         res_timeout_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         eval_start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (win_valid_i && win_ready_q) begin
                  res_tag_q     <= win_tag_i;
                  stage_idx_q   <= '0;
                  tbl_addr_q    <= '0;
                  res_stages_q  <= '0;
                  res_timeout_q <= 1'b0;
                  res_detect_q  <= 1'b0;
                  win_ready_q   <= 1'b0;
                  busy_q        <= 1'b1;
                  state_q       <= S_FETCH;
               end
            end

            // Address was presented on entry; ROM data appears next cycle.
            S_FETCH: state_q <= S_LATCH;

            S_LATCH: begin
               eval_count_q <= entry_count(tbl_data_i);
               eval_base_q  <= entry_base(tbl_data_i);
               if (entry_count(tbl_data_i) == 16'd0) begin
                  state_q <= S_NEXT;
               end else begin
                  eval_start_q <= 1'b1;
                  state_q      <= S_START;
               end
            end

            S_START: state_q <= S_WAIT;

            // A done pulse in the expiry cycle still counts as a real result.
            S_WAIT: begin
               if (eval_done_i) begin
                  if (eval_pass_i) begin
                     state_q <= S_NEXT;
                  end else begin
                     res_detect_q <= 1'b0;
                     res_valid_q  <= 1'b1;
                     state_q      <= S_REPORT;
                  end
               end else if (wd_expired) begin
                  res_detect_q  <= 1'b0;
                  res_timeout_q <= 1'b1;
                  res_valid_q   <= 1'b1;
                  state_q       <= S_REPORT;
               end
            end

            S_NEXT: begin
               if (res_stages_q != 8'hFF) begin
                  res_stages_q <= res_stages_q + 8'd1;
               end
               if (stage_idx_q == IDX_W'(NUM_STAGES - 1)) begin
                  res_detect_q <= 1'b1;
                  res_valid_q  <= 1'b1;
                  state_q      <= S_REPORT;
               end else begin
                  stage_idx_q <= stage_idx_q + IDX_W'(1);
                  tbl_addr_q  <= tbl_addr_q + ADDR_W'(1);
                  state_q     <= S_FETCH;
               end
            end

            S_REPORT: begin
               if (res_ready_i) begin
                  res_valid_q <= 1'b0;
                  win_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end

            default: begin
               res_valid_q <= 1'b0;
               win_ready_q <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign win_ready_o   = win_ready_q;
   assign tbl_addr_o    = tbl_addr_q;
   assign eval_start_o  = eval_start_q;
   assign eval_base_o   = eval_base_q;
   assign eval_count_o  = eval_count_q;
   assign res_valid_o   = res_valid_q;
   assign res_detect_o  = res_detect_q;
   assign res_tag_o     = res_tag_q;
   assign res_stages_o  = res_stages_q;
   assign res_timeout_o = res_timeout_q;
   assign busy_o        = busy_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_haar_cascade_scheduler.sv
// Directed bench for haar_cascade_scheduler: ROM and evaluator models, a
// scoreboard of expected evaluator launches and hand-computed latencies.
`timescale 1ns/1ps
module tb_haar_cascade_scheduler;
   import haar_pkg::*;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   always #5 clk = ~clk;

   logic        win_valid = 1'b0;
   logic        win_ready;
   logic [15:0] win_tag = '0;
   logic [15:0] tbl_addr;
   logic [31:0] tbl_data = '0;
   logic        eval_start;
   logic [15:0] eval_base;
   logic [15:0] eval_count;
   logic        eval_done = 1'b0;
   logic        eval_pass = 1'b0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic        res_detect;
   logic [15:0] res_tag;
   logic [7:0]  res_stages;
   logic        res_timeout;
   logic        busy;
   state_t      state;

   haar_cascade_scheduler #(
      .NUM_STAGES (3),
      .ADDR_W     (16),
      .TAG_W      (16),
      .TIMEOUT    (16)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .win_valid_i   (win_valid),
      .win_ready_o   (win_ready),
      .win_tag_i     (win_tag),
      .tbl_addr_o    (tbl_addr),
      .tbl_data_i    (tbl_data),
      .eval_start_o  (eval_start),
      .eval_base_o   (eval_base),
      .eval_count_o  (eval_count),
      .eval_done_i   (eval_done),
      .eval_pass_i   (eval_pass),
      .res_valid_o   (res_valid),
      .res_ready_i   (res_ready),
      .res_detect_o  (res_detect),
      .res_tag_o     (res_tag),
      .res_stages_o  (res_stages),
      .res_timeout_o (res_timeout),
      .busy_o        (busy),
      .state_o       (state)
   );

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- models ----------------
   logic [31:0] rom [0:7];
   always @(posedge clk) tbl_data <= rom[tbl_addr[2:0]];

   int eval_lat   = 5;
   int fail_stage = 99;
   bit eval_hang  = 1'b0;
   int n_starts   = 0;

   always begin
      @(posedge clk);
      if (eval_start === 1'b1) begin
         n_starts++;
         if (!eval_hang) begin
            repeat (eval_lat - 1) @(posedge clk);
            #1;
            eval_done = 1'b1;
            eval_pass = ((n_starts - 1) != fail_stage);
            @(posedge clk);
            #1;
            eval_done = 1'b0;
            eval_pass = 1'b0;
         end
      end
   end

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt++;

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];     // expected {eval_count, eval_base} per launch
   logic [15:0] addr_q[$];    // observed fetch addresses
   int          fcyc_q[$];    // cycle of each fetch

   always @(negedge clk) begin
      if (!reset && eval_start === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_eval_start", {eval_count, eval_base}, 32'hDEAD_DEAD);
         end else begin
            check("eval_count_base", {eval_count, eval_base}, exp_q.pop_front());
         end
      end
      if (!reset && state == S_FETCH) begin
         addr_q.push_back(tbl_addr);
         fcyc_q.push_back(cyc_cnt);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_table(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
      rom[0] = e0;
      rom[1] = e1;
      rom[2] = e2;
   endtask

   task automatic begin_window(input logic [15:0] tag);
      addr_q.delete();
      fcyc_q.delete();
      n_starts = 0;
      @(negedge clk);
      check("win_ready_idle", 32'(win_ready), 32'd1);
      win_valid = 1'b1;
      win_tag   = tag;
      @(posedge clk);
      #1;
      win_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (res_valid !== 1'b1 && lat < 300);
      if (res_valid !== 1'b1) check("res_valid_wait_bound", 32'd0, 32'd1);
   endtask

   task automatic finish_result();
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      check("res_valid_drop", 32'(res_valid), 32'd0);
      check("win_ready_back", 32'(win_ready), 32'd1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int lat;
      int bad;
      int stale;
      for (int i = 0; i < 8; i++) rom[i] = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_win_ready", 32'(win_ready), 32'd1);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_eval_start", 32'(eval_start), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tbl_addr", 32'(tbl_addr), 32'd0);
      check("rst_state", 32'(state), 32'(S_IDLE));
      @(negedge clk);
      reset = 1'b0;

      // All stages pass, L=5: 3 * 9 cycles.
      load_table(32'h0003_0000, 32'h0002_0003, 32'h0004_0005);
      exp_q = '{32'h0003_0000, 32'h0002_0003, 32'h0004_0005};
      eval_lat = 5; fail_stage = 99; eval_hang = 1'b0;
      begin_window(16'h00A1);
      wait_result(lat);
      check("pass_latency", lat, 32'd27);
      check("pass_detect", 32'(res_detect), 32'd1);
      check("pass_stages", 32'(res_stages), 32'd3);
      check("pass_tag", 32'(res_tag), 32'h00A1);
      check("pass_timeout", 32'(res_timeout), 32'd0);
      check("pass_fetches", addr_q.size(), 32'd3);
      for (int i = 0; i < addr_q.size() && i < 3; i++) check("pass_fetch_addr", 32'(addr_q[i]), i);
      check("pass_sb_empty", exp_q.size(), 32'd0);
      finish_result();

      // Stage 1 fails: 9 + 8 cycles.
      exp_q = '{32'h0003_0000, 32'h0002_0003};
      fail_stage = 1;
      begin_window(16'h0055);
      wait_result(lat);
      check("fail_latency", lat, 32'd17);
      check("fail_detect", 32'(res_detect), 32'd0);
      check("fail_stages", 32'(res_stages), 32'd1);
      check("fail_timeout", 32'(res_timeout), 32'd0);
      check("fail_starts", n_starts, 32'd2);
      check("fail_fetches", addr_q.size(), 32'd2);
      bad = 0;
      foreach (addr_q[i]) if (addr_q[i] == 16'd2) bad++;
      check("fail_no_addr2", bad, 32'd0);
      finish_result();

      // Zero-count first stage: 3 + 9 + 9 cycles.
      load_table(32'h0000_0000, 32'h0002_0003, 32'h0004_0005);
      exp_q = '{32'h0002_0003, 32'h0004_0005};
      fail_stage = 99;
      begin_window(16'h0077);
      wait_result(lat);
      check("zero_latency", lat, 32'd21);
      check("zero_starts", n_starts, 32'd2);
      check("zero_stages", 32'(res_stages), 32'd3);
      check("zero_detect", 32'(res_detect), 32'd1);
      if (fcyc_q.size() >= 2) check("zero_fetch_gap", fcyc_q[1] - fcyc_q[0], 32'd3);
      else check("zero_fetch_count", fcyc_q.size(), 32'd2);
      finish_result();

      // Watchdog: TIMEOUT=16, no done; FETCH+LATCH+START then 17 WAIT cycles.
      load_table(32'h0003_0000, 32'h0002_0003, 32'h0004_0005);
      exp_q = '{32'h0003_0000};
      eval_hang = 1'b1;
      begin_window(16'h0099);
      wait_result(lat);
      check("to_latency", lat, 32'd20);
      check("to_detect", 32'(res_detect), 32'd0);
      check("to_timeout", 32'(res_timeout), 32'd1);
      check("to_stages", 32'(res_stages), 32'd0);
      check("to_starts", n_starts, 32'd1);
      finish_result();
      eval_hang = 1'b0;

      // Backpressure: result held, second window waits for the handshake.
      exp_q = '{32'h0003_0000, 32'h0002_0003, 32'h0004_0005};
      begin_window(16'h00B2);
      wait_result(lat);
      check("bp_latency", lat, 32'd27);
      @(negedge clk);
      win_valid = 1'b1;
      win_tag   = 16'h00C3;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (win_ready !== 1'b0) bad++;
         if (res_valid !== 1'b1 || res_tag !== 16'h00B2 || res_detect !== 1'b1 ||
             res_stages !== 8'd3 || res_timeout !== 1'b0) bad++;
      end
      check("bp_hold_stable", bad, 32'd0);
      exp_q = '{32'h0003_0000, 32'h0002_0003, 32'h0004_0005};
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      check("bp_state_idle", 32'(state), 32'(S_IDLE));
      check("bp_win_ready", 32'(win_ready), 32'd1);
      addr_q.delete();
      fcyc_q.delete();
      n_starts = 0;
      @(posedge clk);
      #1;
      win_valid = 1'b0;
      check("bp_second_accept", 32'(state), 32'(S_FETCH));
      wait_result(lat);
      check("bp2_latency", lat, 32'd27);
      check("bp2_tag", 32'(res_tag), 32'h00C3);
      check("bp2_detect", 32'(res_detect), 32'd1);
      finish_result();

      // Reset during WAIT of stage 1.
      exp_q = '{32'h0003_0000, 32'h0002_0003, 32'h0004_0005};
      begin_window(16'h00E5);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(state == S_WAIT && n_starts == 2) && lat < 200);
      check("rstw_reached_wait", 32'(state == S_WAIT && n_starts == 2), 32'd1);
      reset = 1'b1;
      #1;
      check("rstw_state", 32'(state), 32'(S_IDLE));
      check("rstw_eval_start", 32'(eval_start), 32'd0);
      check("rstw_res_valid", 32'(res_valid), 32'd0);
      check("rstw_win_ready", 32'(win_ready), 32'd1);
      check("rstw_busy", 32'(busy), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      stale = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (res_valid !== 1'b0 || state !== S_IDLE) stale++;
      end
      check("rstw_no_stale", stale, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
